// File: rtl/macu_pe_db.sv
// Weight-stationary systolic MAC processing element with a double-buffered
// weight (shadow/active), a daisy-chained weight load, valid tracking,
// east-bound activation forwarding, optional saturation with a sticky
// overflow flag, and a per-beat bypass of the product.
//
// Pipeline, taking edge k as the edge that samples xi:
//   k   : x_r <= xi, v1 <= xi_valid          (xo/xo_valid show these)
//   k+1 : p_r <= x_r * active, v2 <= v1
//   k+2 : co  <= f(ci + p_r) when v2, co_valid <= v2
// Handshake: there is no back-pressure. xi is qualified by xi_valid and co by
// co_valid. A beat is accepted on every edge where xi_valid is high, and the
// matching ci/bypass must be presented for the edge two cycles later.
module macu_pe_db #(
  parameter int DW  = 8,
  parameter int CW  = 24,
  parameter int OW  = 24,
  parameter int SAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] xi,
  input  logic          xi_valid,
  output logic [DW-1:0] xo,
  output logic          xo_valid,
  input  logic [DW-1:0] wi,
  input  logic          w_load,
  output logic [DW-1:0] wo,
  input  logic          w_swap,
  input  logic          bypass,
  input  logic [CW-1:0] ci,
  output logic [OW-1:0] co,
  output logic          co_valid,
  output logic          ovf,
  input  logic          clr_ovf
);

  // Product width, exact sum width, and a working width that also covers OW.
  localparam int PW = 2 * DW;
  localparam int SW = ((CW > PW) ? CW : PW) + 1;
  localparam int XW = (SW > OW) ? SW : OW;

  logic signed [DW-1:0] x_r;
  logic signed [DW-1:0] shadow;
  logic signed [DW-1:0] active;
  logic signed [PW-1:0] p_r;
  logic                 v1;
  logic                 v2;

  logic signed [XW-1:0] ci_ext;
  logic signed [XW-1:0] p_ext;
  logic signed [XW-1:0] sum;
  logic [XW-OW:0]       sum_top;
  logic                 sum_fits;
  logic [OW-1:0]        sum_res;

  assign xo       = x_r;
  assign xo_valid = v1;
  assign wo       = shadow;

  // Input stage: capture the activation and its qualifier every edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_r <= '0;
      v1  <= 1'b0;
    end else begin
      x_r <= xi;
      v1  <= xi_valid;
    end
  end

  // Weight buffers: load fills shadow, swap copies the pre-edge shadow to active.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
      active <= '0;
    end else begin
      if (w_load) shadow <= wi;
      if (w_swap) active <= shadow;
    end
  end

  // Product stage: multiplies with the weight active before this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_r <= '0;
      v2  <= 1'b0;
    end else begin
      p_r <= x_r * active;
      v2  <= v1;
    end
  end

  // Sum: sign-extend both operands, detect OW range overflow, clamp or wrap.
  always_comb begin
    ci_ext   = {{(XW - CW){ci[CW-1]}}, ci};
    p_ext    = bypass ? '0 : {{(XW - PW){p_r[PW-1]}}, p_r};
    sum      = ci_ext + p_ext;
    sum_top  = sum[XW-1:OW-1];
    sum_fits = (&sum_top) | ~(|sum_top);
    if (SAT != 0 && !sum_fits) begin
      sum_res = sum[XW-1] ? {1'b1, {(OW - 1){1'b0}}} : {1'b0, {(OW - 1){1'b1}}};
    end else begin
      sum_res = sum[OW-1:0];
    end
  end

  // Output stage: update co only for valid beats; ovf is sticky, set beats clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      co       <= '0;
      co_valid <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      if (v2) co <= sum_res;
      co_valid <= v2;
      if (v2 && !sum_fits) ovf <= 1'b1;
      else if (clr_ovf)    ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_macu_pe_db.sv
// Self-checking bench for macu_pe_db: directed scenarios plus a randomized
// stream compared against an arithmetic reference model.
module tb_macu_pe_db;

  localparam int DW = 8;
  localparam int CW = 24;
  localparam int OW = 24;
  localparam longint MAXV = (longint'(1) << (OW - 1)) - 1;
  localparam longint MINV = -(longint'(1) << (OW - 1));
  localparam int N = 400;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] xi;
  logic          xi_valid;
  logic [DW-1:0] xo;
  logic          xo_valid;
  logic [DW-1:0] wi;
  logic          w_load;
  logic [DW-1:0] wo;
  logic          w_swap;
  logic          bypass;
  logic [CW-1:0] ci;
  logic [OW-1:0] co;
  logic          co_valid;
  logic          ovf;
  logic          clr_ovf;

  int checks;
  int errors;

  macu_pe_db #(.DW(DW), .CW(CW), .OW(OW), .SAT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .xi(xi), .xi_valid(xi_valid), .xo(xo), .xo_valid(xo_valid),
    .wi(wi), .w_load(w_load), .wo(wo), .w_swap(w_swap),
    .bypass(bypass), .ci(ci), .co(co), .co_valid(co_valid),
    .ovf(ovf), .clr_ovf(clr_ovf)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    xi = '0; xi_valid = 1'b0; wi = '0; w_load = 1'b0; w_swap = 1'b0;
    bypass = 1'b0; ci = '0; clr_ovf = 1'b0;
  endtask

  task automatic pulse_reset();
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic load_weight(input int w);
    wi = DW'(w); w_load = 1'b1; w_swap = 1'b0;
    tick();
    w_load = 1'b0; w_swap = 1'b1;
    tick();
    w_swap = 1'b0;
  endtask

  // One valid beat with its ci two cycles later; returns co/co_valid after the sum edge.
  task automatic run_beat(input int x, input int c, input bit byp,
                          output logic [OW-1:0] co_s, output logic cv_s);
    xi = DW'(x); xi_valid = 1'b1;
    tick();
    xi = '0; xi_valid = 1'b0;
    tick();
    ci = CW'(c); bypass = byp;
    tick();
    co_s = co; cv_s = co_valid;
    ci = '0; bypass = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    checks++;
    if ({co, co_valid, ovf, xo, xo_valid, wo} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: co=%0h cv=%0b ovf=%0b xo=%0h xov=%0b wo=%0h expected all 0",
               co, co_valid, ovf, xo, xo_valid, wo);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (co_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_cv: co_valid=%0b expected 0", co_valid);
    end
  endtask

  task automatic test_basic();
    load_weight(3);
    xi = 8'd5; xi_valid = 1'b1;
    tick();
    checks++;
    if (xo !== 8'd5 || xo_valid !== 1'b1 || co_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_forward: xo=%0d xov=%0b cv=%0b expected 5 1 0", xo, xo_valid, co_valid);
    end
    xi = '0; xi_valid = 1'b0;
    tick();
    checks++;
    if (co_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_early_cv: co_valid=%0b expected 0", co_valid);
    end
    ci = CW'(10);
    tick();
    checks++;
    if (co !== OW'(25) || co_valid !== 1'b1) begin
      errors++;
      $display("FAIL basic_co: co=%0d cv=%0b expected 25 1", $signed(co), co_valid);
    end
    ci = '0;
    tick();
    checks++;
    if (co !== OW'(25) || co_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_hold: co=%0d cv=%0b expected 25 0", $signed(co), co_valid);
    end
  endtask

  task automatic test_signed();
    logic [OW-1:0] c; logic v;
    load_weight(-128);
    run_beat(-128, 0, 1'b0, c, v);
    checks++;
    if (c !== OW'(16384) || v !== 1'b1) begin
      errors++;
      $display("FAIL signed_min_min: co=%0d cv=%0b expected 16384 1", $signed(c), v);
    end
    load_weight(127);
    run_beat(-128, -1, 1'b0, c, v);
    checks++;
    if (c !== OW'(-16257) || v !== 1'b1) begin
      errors++;
      $display("FAIL signed_mixed: co=%0d cv=%0b expected -16257 1", $signed(c), v);
    end
  endtask

  task automatic test_saturation();
    logic [OW-1:0] c; logic v;
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    load_weight(127);
    run_beat(127, 8388600, 1'b0, c, v);
    checks++;
    if (c !== OW'(8388607) || ovf !== 1'b1) begin
      errors++;
      $display("FAIL sat_pos: co=%0d ovf=%0b expected 8388607 1", $signed(c), ovf);
    end
    tick();
    tick();
    checks++;
    if (ovf !== 1'b1) begin
      errors++;
      $display("FAIL sat_sticky: ovf=%0b expected 1", ovf);
    end
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL sat_clear: ovf=%0b expected 0", ovf);
    end
    run_beat(1, 100, 1'b0, c, v);
    checks++;
    if (c !== OW'(227) || ovf !== 1'b0) begin
      errors++;
      $display("FAIL sat_no_ovf: co=%0d ovf=%0b expected 227 0", $signed(c), ovf);
    end
    xi = 8'd127; xi_valid = 1'b1;
    tick();
    xi = '0; xi_valid = 1'b0;
    tick();
    ci = CW'(8388600); clr_ovf = 1'b1;
    tick();
    ci = '0; clr_ovf = 1'b0;
    checks++;
    if (ovf !== 1'b1) begin
      errors++;
      $display("FAIL sat_set_wins: ovf=%0b expected 1", ovf);
    end
    run_beat(-127, -8388600, 1'b0, c, v);
    checks++;
    if (c !== OW'(-8388608) || v !== 1'b1) begin
      errors++;
      $display("FAIL sat_neg: co=%0d cv=%0b expected -8388608 1", $signed(c), v);
    end
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
  endtask

  task automatic test_swap_stream();
    int exp_s[4] = '{2, 4, 27, 36};
    load_weight(2);
    wi = 8'd9; w_load = 1'b1;
    tick();
    w_load = 1'b0;
    for (int t = 0; t < 6; t++) begin
      xi = (t < 4) ? DW'(t + 1) : '0;
      xi_valid = (t < 4);
      w_load = (t == 2); w_swap = (t == 2); wi = 8'd7; ci = '0;
      tick();
      if (t >= 2) begin
        checks++;
        if (co !== OW'(exp_s[t-2]) || co_valid !== 1'b1) begin
          errors++;
          $display("FAIL swap_stream beat %0d: co=%0d cv=%0b expected %0d 1",
                   t - 2, $signed(co), co_valid, exp_s[t-2]);
        end
      end
    end
    idle();
    checks++;
    if (wo !== 8'd7) begin
      errors++;
      $display("FAIL swap_wo: wo=%0d expected 7", wo);
    end
  endtask

  task automatic test_bubble_bypass();
    bit xv[5]     = '{1, 0, 1, 0, 0};
    int xin[5]    = '{3, 9, 5, 0, 0};
    int ci_t[5]   = '{0, 0, 100, 555, -77};
    bit byp[5]    = '{0, 0, 0, 0, 1};
    int exp_co[3] = '{112, 112, -77};
    bit exp_cv[3] = '{1, 0, 1};
    load_weight(4);
    for (int t = 0; t < 5; t++) begin
      xi = DW'(xin[t]); xi_valid = xv[t]; ci = CW'(ci_t[t]); bypass = byp[t];
      tick();
      checks++;
      if (xo_valid !== xv[t]) begin
        errors++;
        $display("FAIL bubble_xov edge %0d: xo_valid=%0b expected %0b", t, xo_valid, xv[t]);
      end
      if (t >= 2) begin
        checks++;
        if (co !== OW'(exp_co[t-2]) || co_valid !== exp_cv[t-2]) begin
          errors++;
          $display("FAIL bubble_co edge %0d: co=%0d cv=%0b expected %0d %0b",
                   t, $signed(co), co_valid, exp_co[t-2], exp_cv[t-2]);
        end
      end
    end
    idle();
  endtask

  task automatic test_midstream_reset();
    logic [OW-1:0] c; logic v;
    load_weight(100);
    run_beat(100, 8388600, 1'b0, c, v);
    xi = 8'd1; xi_valid = 1'b1;
    tick();
    xi = 8'd2;
    tick();
    #2 rst_n = 1'b0;
    idle();
    #1;
    checks++;
    if ({co, co_valid, ovf, wo, xo, xo_valid} !== '0) begin
      errors++;
      $display("FAIL midreset_clear: co=%0h cv=%0b ovf=%0b wo=%0h xo=%0h xov=%0b expected all 0",
               co, co_valid, ovf, wo, xo, xo_valid);
    end
    tick();
    rst_n = 1'b1;
    for (int t = 0; t < 3; t++) begin
      tick();
      checks++;
      if (co_valid !== 1'b0) begin
        errors++;
        $display("FAIL midreset_stale_cv cycle %0d: co_valid=%0b expected 0", t, co_valid);
      end
    end
    run_beat(5, 1, 1'b0, c, v);
    checks++;
    if (c !== OW'(1) || v !== 1'b1) begin
      errors++;
      $display("FAIL midreset_weight_zero: co=%0d cv=%0b expected 1 1", $signed(c), v);
    end
  endtask

  // Scoreboard: stimulus is generated up front, the model fills the expected
  // queues from the arithmetic rules, then the driver replays and compares.
  int xi_a[N], wi_a[N], ci_a[N];
  bit xv_a[N], wl_a[N], ws_a[N], byp_a[N], clr_a[N];
  logic [OW-1:0] exp_q[$];
  bit            exp_cv_q[$];
  bit            exp_ovf_q[$];
  logic [DW-1:0] exp_wo_q[$];

  task automatic test_random();
    int weff[N];
    int sh, act;
    bit m_ovf, set;
    longint s;
    logic [OW-1:0] m_co, e_co;
    bit e_cv, e_ovf;
    logic [DW-1:0] e_wo;
    for (int e = 0; e < N; e++) begin
      xi_a[e]  = int'($urandom_range(0, 255)) - 128;
      wi_a[e]  = int'($urandom_range(0, 255)) - 128;
      xv_a[e]  = (e < N - 2) && ($urandom_range(0, 3) != 0);
      wl_a[e]  = ($urandom_range(0, 5) == 0);
      ws_a[e]  = ($urandom_range(0, 5) == 0);
      byp_a[e] = ($urandom_range(0, 5) == 0);
      clr_a[e] = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0)
        ci_a[e] = ($urandom_range(0, 1) == 1) ? 8388607 - int'($urandom_range(0, 20000))
                                              : -8388608 + int'($urandom_range(0, 20000));
      else
        ci_a[e] = int'($urandom_range(0, 16777215)) - 8388608;
    end
    sh = 0; act = 0; m_ovf = 1'b0; m_co = '0;
    for (int e = 0; e < N; e++) begin
      if (ws_a[e]) act = sh;
      if (wl_a[e]) sh = wi_a[e];
      weff[e] = act;
      set = 1'b0;
      if (e >= 2 && xv_a[e-2]) begin
        s = longint'(ci_a[e]) + (byp_a[e] ? 64'sd0 : longint'(xi_a[e-2] * weff[e-2]));
        if (s > MAXV)      begin s = MAXV; set = 1'b1; end
        else if (s < MINV) begin s = MINV; set = 1'b1; end
        m_co = OW'(s);
      end
      m_ovf = set ? 1'b1 : (clr_a[e] ? 1'b0 : m_ovf);
      exp_q.push_back(m_co);
      exp_cv_q.push_back(e >= 2 && xv_a[e-2]);
      exp_ovf_q.push_back(m_ovf);
      exp_wo_q.push_back(DW'(sh));
    end
    pulse_reset();
    for (int e = 0; e < N; e++) begin
      xi = DW'(xi_a[e]); xi_valid = xv_a[e]; wi = DW'(wi_a[e]);
      w_load = wl_a[e]; w_swap = ws_a[e]; bypass = byp_a[e];
      ci = CW'(ci_a[e]); clr_ovf = clr_a[e];
      tick();
      e_co = exp_q.pop_front();
      e_cv = exp_cv_q.pop_front();
      e_ovf = exp_ovf_q.pop_front();
      e_wo = exp_wo_q.pop_front();
      checks++;
      if (co !== e_co || co_valid !== e_cv || ovf !== e_ovf) begin
        errors++;
        $display("FAIL random_sum edge %0d: co=%0d cv=%0b ovf=%0b expected %0d %0b %0b",
                 e, $signed(co), co_valid, ovf, $signed(e_co), e_cv, e_ovf);
      end
      checks++;
      if (xo !== DW'(xi_a[e]) || xo_valid !== xv_a[e] || wo !== e_wo) begin
        errors++;
        $display("FAIL random_fwd edge %0d: xo=%0h xov=%0b wo=%0h expected %0h %0b %0h",
                 e, xo, xo_valid, wo, DW'(xi_a[e]), xv_a[e], e_wo);
      end
    end
    idle();
  endtask

  // Sequencer and final report
  initial begin
    checks = 0;
    errors = 0;
    idle();
    test_reset();
    test_basic();
    test_signed();
    test_saturation();
    test_swap_stream();
    test_bubble_bypass();
    test_midstream_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
